// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I iterative-shift ALU: op codes, FSM states and the
// single-cycle result function.
package alu_pkg;

    localparam int unsigned ALU_XLEN = 32;

    // {funct7[5], funct3}; execute decodes with the same constants.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } alu_st_e;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_kind_e;

    // funct3 001 (SLL) and 101 (SRL/SRA) are the only iterative ops.
    function automatic logic is_shift_op(input logic [3:0] op);
        return op[1:0] == 2'b01;
    endfunction

    function automatic shift_kind_e shift_kind(input logic [3:0] op);
        if (!op[2]) begin
            return SH_SLL;
        end
        return op[3] ? SH_SRA : SH_SRL;
    endfunction

    // Full combinational result; shifts are only taken from here when shamt is zero.
    function automatic logic [ALU_XLEN-1:0] alu_single(input logic [3:0]          op,
                                                       input logic [ALU_XLEN-1:0] a,
                                                       input logic [ALU_XLEN-1:0] b);
        logic [ALU_XLEN-1:0] r;
        unique case (op[2:0])
            3'b000: r = op[3] ? (a - b) : (a + b);
            3'b001: r = a << b[4:0];
            3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011: r = (a < b) ? 32'd1 : 32'd0;
            3'b100: r = a ^ b;
            3'b101: r = op[3] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110: r = a | b;
            3'b111: r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/u_alu_shift.sv
// One-bit-per-cycle shifter: holds the operand, remaining count and latched shift kind.
// done is high in the cycle whose shift step brings the count from 1 to 0.
module u_alu_shift
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic            kill,
    input  shift_kind_e     kind,
    input  logic [4:0]      shamt,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout,
    output logic            done
);

    logic [XLEN-1:0] acc_q, acc_d, acc_step;
    logic [4:0]      cnt_q, cnt_d;
    shift_kind_e     kind_q, kind_d;

    always_comb begin
        unique case (kind_q)
            SH_SLL:  acc_step = {acc_q[XLEN-2:0], 1'b0};
            SH_SRL:  acc_step = {1'b0, acc_q[XLEN-1:1]};
            SH_SRA:  acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: acc_step = acc_q;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        kind_d = kind_q;
        if (kill) begin
            cnt_d = '0;
        end else if (load) begin
            acc_d  = din;
            cnt_d  = shamt;
            kind_d = kind;
        end else if (cnt_q != '0) begin
            acc_d = acc_step;
            cnt_d = cnt_q - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            kind_q <= SH_SLL;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
        end
    end

    assign dout = acc_step;
    assign done = (cnt_q == 5'd1);

endmodule

// File: rtl/u_alu.sv
// RV32I execute-stage ALU: single-cycle add/compare/logic, iterative shifts behind a
// req/vld/busy handshake. All outputs come straight from registers.
module u_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            alu_req,
    input  logic            alu_kill,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_i1,
    input  logic [XLEN-1:0] alu_i2,
    output logic [XLEN-1:0] alu_o,
    output logic            alu_vld,
    output logic            alu_busy
);

    alu_st_e         state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            vld_q, vld_d;

    logic            start_shift;
    logic            sh_load;
    logic            sh_done;
    logic [XLEN-1:0] sh_dout;
    logic [XLEN-1:0] single_res;

    assign start_shift = is_shift_op(alu_op) && (alu_i2[4:0] != 5'd0);
    assign single_res  = alu_single(alu_op, alu_i1, alu_i2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (alu_kill) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (alu_req && start_shift) begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Kill suppresses every side effect, including a request arriving in the same cycle.
    always_comb begin
        sh_load = 1'b0;
        res_d   = res_q;
        vld_d   = 1'b0;
        if (!alu_kill) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (alu_req) begin
                        if (start_shift) begin
                            sh_load = 1'b1;
                        end else begin
                            res_d = single_res;
                            vld_d = 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        res_d = sh_dout;
                        vld_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end

    u_alu_shift #(
        .XLEN (XLEN)
    ) u_shift (
        .clk   (clk),
        .rstn  (rstn),
        .load  (sh_load),
        .kill  (alu_kill),
        .kind  (shift_kind(alu_op)),
        .shamt (alu_i2[4:0]),
        .din   (alu_i1),
        .dout  (sh_dout),
        .done  (sh_done)
    );

    assign alu_o    = res_q;
    assign alu_vld  = vld_q;
    assign alu_busy = (state_q == ST_SHIFT);

endmodule
